// File: rtl/alu_pkg.sv
// alu_pkg -- shared definitions for the sequential ALU slice.
//   ALU_WIDTH : default operand/result width
//   alu_op_e  : operation encodings carried on alu_op
//   state_e   : control FSM states (MULT exists only when ALU_MULT_EN is defined)
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  typedef enum logic [2:0] {
    OP_AND  = 3'b000,
    OP_OR   = 3'b001,
    OP_ADD  = 3'b010,
    OP_SUB  = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOR  = 3'b101,
    OP_SLT  = 3'b110,
    OP_MULT = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1
`ifdef ALU_MULT_EN
    ,
    MULT = 2'd2
`endif
  } state_e;

endpackage

// File: rtl/mult32_shift_add.sv
// mult32_shift_add -- iterative unsigned shift-add multiplier, one bit per step.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture mcand/mplier and clear the accumulator
//   step       : perform one shift-add iteration
//   mcand      : multiplicand
//   mplier     : multiplier
//   product    : accumulator value as it will be after this cycle's edge
//                (includes the current step when step=1), so the caller can
//                register the full product on the same edge as the last step
module mult32_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  // Low half starts as the multiplier and is consumed LSB-first while
  // product bits shift in from the top.
  always_comb begin
    addend  = acc_lo[0] ? mcand_q : '0;
    sum     = {1'b0, acc_hi} + {1'b0, addend};
    hi_nxt  = sum[WIDTH:1];
    lo_nxt  = {sum[0], acc_lo[WIDTH-1:1]};
    product = step ? {hi_nxt, lo_nxt} : {acc_hi, acc_lo};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
    end else if (load) begin
      mcand_q <= mcand;
      acc_hi  <= '0;
      acc_lo  <= mplier;
    end else if (step) begin
      acc_hi  <= hi_nxt;
      acc_lo  <= lo_nxt;
    end
  end

endmodule

// File: rtl/alu_seq_32.sv
// alu_seq_32 -- sequential ALU: single-cycle logic/arith ops, iterative multiply.
//   clk, rst_n      : clock, synchronous active-low reset
//   start           : request, accepted only while idle
//   alu_op          : operation, sampled with start
//   input1, input2  : operands A and B, sampled with start
//   busy            : high whenever not idle
//   done            : one-cycle pulse, outputs below are valid
//   result          : result (low word for multiply)
//   hi              : high word of multiply, untouched by other ops
//   zero            : result == 0
//   overflow        : signed overflow of ADD/SUB, 0 otherwise
// Build option: ALU_MULT_EN enables the MULT state and multiplier; without it
// op 111 completes through EXEC with result 0 and hi is constant 0.
module alu_seq_32
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] input1,
  input  logic [WIDTH-1:0] input2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow
);

  state_e           state;
  state_e           state_nxt;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             load_ops;
  logic             fin_exec;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] exec_res;
  logic             exec_ovf;

`ifdef ALU_MULT_EN
  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [CW-1:0]      cnt;
  logic               mult_load;
  logic               mult_step;
  logic               fin_mult;
  logic [WIDTH-1:0]   hi_q;
  logic [2*WIDTH-1:0] product;

  // Multiplier captures operands straight from the ports on the accepting
  // edge, in parallel with the local operand latches.
  mult32_shift_add #(
    .WIDTH(WIDTH)
  ) u_mult (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mult_load),
    .step   (mult_step),
    .mcand  (input1),
    .mplier (input2),
    .product(product)
  );

  assign hi = hi_q;
`else
  assign hi = '0;
`endif

  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    sum      = a_q + b_q;
    diff     = a_q - b_q;
    case (op_q)
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_ADD: begin
        exec_res = sum;
        exec_ovf = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB: begin
        exec_res = diff;
        exec_ovf = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_XOR:  exec_res = a_q ^ b_q;
      OP_NOR:  exec_res = ~(a_q | b_q);
      OP_SLT:  exec_res = WIDTH'($signed(a_q) < $signed(b_q));
      default: exec_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    load_ops  = 1'b0;
    fin_exec  = 1'b0;
`ifdef ALU_MULT_EN
    mult_load = 1'b0;
    mult_step = 1'b0;
    fin_mult  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          load_ops  = 1'b1;
          state_nxt = EXEC;
`ifdef ALU_MULT_EN
          if (alu_op == OP_MULT) begin
            mult_load = 1'b1;
            state_nxt = MULT;
          end
`endif
        end
      end
      EXEC: begin
        fin_exec  = 1'b1;
        state_nxt = IDLE;
      end
`ifdef ALU_MULT_EN
      MULT: begin
        mult_step = 1'b1;
        if (cnt == LAST) begin
          fin_mult  = 1'b1;
          state_nxt = IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= OP_AND;
      a_q      <= '0;
      b_q      <= '0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b1;
      overflow <= 1'b0;
`ifdef ALU_MULT_EN
      cnt      <= '0;
      hi_q     <= '0;
`endif
    end else begin
      done <= fin_exec
`ifdef ALU_MULT_EN
              | fin_mult
`endif
              ;
      if (load_ops) begin
        op_q <= alu_op_e'(alu_op);
        a_q  <= input1;
        b_q  <= input2;
      end
      if (fin_exec) begin
        result   <= exec_res;
        zero     <= (exec_res == '0);
        overflow <= exec_ovf;
      end
`ifdef ALU_MULT_EN
      if (mult_load) begin
        cnt <= '0;
      end else if (mult_step) begin
        cnt <= cnt + 1'b1;
      end
      if (fin_mult) begin
        hi_q     <= product[2*WIDTH-1:WIDTH];
        result   <= product[WIDTH-1:0];
        zero     <= (product[WIDTH-1:0] == '0);
        overflow <= 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/alu_seq_32.md
ALU_SEQ_32 -- requirements
Module: alu_seq_32

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port start  input  1  request; accepted only in IDLE.
REQ-005 SHALL have port alu_op  input  3  operation select, sampled with start.
REQ-006 SHALL have port input1  input  WIDTH  operand A, sampled with start.
REQ-007 SHALL have port input2  input  WIDTH  operand B, sampled with start.
REQ-008 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-009 SHALL have port done  output  1  one-cycle pulse: result valid.
REQ-010 SHALL have port result  output  WIDTH  registered result (low word for multiply).
REQ-011 SHALL have port hi  output  WIDTH  registered high word of multiply.
REQ-012 SHALL have port zero  output  1  high when result == 0; updated with done.
REQ-013 SHALL have port overflow  output  1  signed overflow of ADD/SUB; 0 for all other ops.

Function
REQ-014 SHALL decode alu_op: 000 AND, 001 OR, 010 ADD, 011 SUB, 100 XOR, 101 NOR, 110 SLT (signed, result 1/0), 111 MULT (unsigned).
REQ-015 SHALL implement FSM states IDLE, EXEC, MULT.
REQ-016 IDLE and start=1: latch alu_op/input1/input2; next state MULT if op 111 (counter cleared), else EXEC.
REQ-017 EXEC: compute, register result/zero/overflow, assert done for one cycle, return IDLE; start-to-done latency 2 cycles.
REQ-018 MULT: one shift-add iteration per cycle, 32 iterations counted 0..31; after iteration 31, register {hi,result} = 64-bit product, done=1, return IDLE; start-to-done latency 33 cycles.
REQ-019 ADD/SUB SHALL wrap modulo 2^WIDTH; overflow = operand signs equal (B inverted for SUB) and result sign differs.
REQ-020 start while busy SHALL be ignored, with no effect on latched operands.
REQ-021 start in the done cycle SHALL be accepted (FSM already IDLE); back-to-back throughput one op per 2 cycles.
REQ-022 result/hi/zero/overflow SHALL hold their last values until the next done.
REQ-023 hi SHALL be written only by MULT; non-multiply ops leave hi unchanged.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force IDLE, counter 0, busy 0, done 0, result 0, hi 0, zero 1, overflow 0.
REQ-025 Reset during EXEC or MULT SHALL abort the operation with no done pulse.

Configuration
REQ-026 Macro ALU_MULT_EN defined: MULT state and multiplier datapath present per REQ-018.
REQ-027 Macro ALU_MULT_EN undefined: op 111 follows the EXEC path with result 0, zero 1, overflow 0, latency 2; hi tied to 0; no MULT state.

Structure
REQ-028 Package alu_pkg SHALL hold WIDTH default, the alu_op encodings, and the FSM state enum.
REQ-029 Iterative multiplier datapath SHALL be sub-module mult32_shift_add (load, step, 64-bit product out); the rest is in alu_seq_32.

Verification
REQ-030 Reset held 2 cycles -> busy 0, done 0, result 0, hi 0, zero 1.
REQ-031 ADD 0x7FFFFFFF + 0x00000001 -> done 2 cycles after start, result 0x80000000, overflow 1, zero 0.
REQ-032 SUB 5 - 5 -> result 0, zero 1, overflow 0; then SLT 0xFFFFFFFF vs 1 -> result 1.
REQ-033 MULT 0xFFFFFFFF x 0xFFFFFFFF (ALU_MULT_EN) -> done 33 cycles after start, hi 0xFFFFFFFE, result 0x00000001; start pulses during busy ignored.
REQ-034 OR 0xF0F0F0F0 | 0x0F0F0000 issued in done cycle of prior op -> accepted, result 0xFFFFF0F0.
REQ-035 rst_n low at cycle 10 of a MULT -> no done, IDLE next cycle, outputs at reset values.
